braille_cell_driver: RTL and testbench
======================================

# braille_cell_driver

Consumes recognised letters from the CNN classifier's result interface (8-bit ASCII `alpha` plus a one-cycle valid strobe) and turns each into a 6-dot Braille cell pattern. Each pattern is held on the actuator outputs for a programmable number of cycles. A small FIFO absorbs back-to-back results, so the classifier never stalls. The block sits between the classifier top and the solenoid/LED pin drivers.

## Interface
- `HOLD_CYCLES`, default 100_000_000: cycles each cell is presented on `o_dots`; legal range ≥ 1.
- `GAP_CYCLES`, default 10_000_000: blank cycles between cells; only used when the gap feature is compiled in; legal range ≥ 1.
- `FIFO_DEPTH`, default 4: letter queue depth; must be a power of two, ≥ 2.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `i_valid`  input  1  one-cycle strobe; `i_alpha` is valid this cycle.
- `i_alpha`  input  8  ASCII letter from the classifier.
- `o_ready`  output  1  queue not full; combinational from the registered count.
- `o_dots`  output  6  bit k = Braille dot k+1; registered.
- `o_dots_valid`  output  1  a cell is being presented; registered.
- `o_busy`  output  1  FSM not IDLE or queue non-empty.
- `o_overflow`  output  1  sticky: a letter was dropped because the queue was full.
- `o_bad_char`  output  1  sticky: a non-letter was dequeued.

## Operation
- Push happens when `i_valid && o_ready`.
  - `i_valid` while full: the letter is dropped, `o_overflow` is set, and the queue is unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
- FSM states: IDLE, HOLD, GAP (GAP exists only with the macro).
  - IDLE: if the queue is non-empty, pop the head, decode it into `o_dots`, set `o_dots_valid`, load the hold counter with HOLD_CYCLES-1, and go to HOLD.
  - HOLD: the counter decrements each cycle. At 0:
    - Macro on: clear `o_dots`/`o_dots_valid`, load the gap counter, go to GAP.
    - Macro off, queue non-empty: pop and decode the next letter in the same edge, stay in HOLD, `o_dots_valid` stays 1 (no bubble).
    - Macro off, queue empty: clear the outputs, go to IDLE.
  - GAP: the counter decrements. At 0, if the queue is non-empty, pop, decode and go to HOLD; otherwise go to IDLE.
- Decode accepts 'a'–'z' and 'A'–'Z' (case-folded by clearing bit 5). Dot sets:
  - a=1, b=12, c=14, d=145, e=15, f=124, g=1245, h=125, i=24, j=245.
  - k–t are a–j plus dot 3.
  - u=136, v=1236, w=2456, x=1346, y=13456, z=1356.
- Any other code produces the blank cell 6'b000000. It is still presented for the full hold time with `o_dots_valid`=1, and it sets `o_bad_char`.

## Timing
- Reset value of all outputs is 0 except `o_ready`=1. Reset also empties the queue, sends the FSM to IDLE and clears the counters. Reset mid-cell drops the cell and queue contents immediately.
- Latency: a letter pushed at edge E0 into an empty, idle block appears on `o_dots`/`o_dots_valid` after edge E0+1.
- Each cell is valid for exactly HOLD_CYCLES cycles.
- Macro off: consecutive queued cells are contiguous.
- Macro on: exactly GAP_CYCLES cycles with `o_dots_valid`=0 separate consecutive cells.
- `o_ready` deasserts the cycle after the count reaches FIFO_DEPTH. A pop in that same cycle frees a slot by the next cycle.
- Counters are sized $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1) and never wrap.

## Configuration
- `BRAILLE_CELL_GAP_EN`:
  - Defined: the GAP state is compiled in, so repeated letters ("ll") are distinguishable on the actuator.
  - Undefined: the GAP state, gap counter and GAP_CYCLES usage are removed, and cells are presented back-to-back.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4.
- Single 'a' (8'h61), macro off → one cycle later `o_dots`=6'b000001, valid for 4 cycles, then 0 and `o_busy`=0.
- 'A' (8'h41) then 'z' (8'h7A) pushed on consecutive cycles, macro off → 6'b000001 for 4 cycles, then 6'b110101 for 4 cycles, no valid gap.
- Same as the previous scenario with `BRAILLE_CELL_GAP_EN` → 4 valid, 2 blank (`o_dots_valid`=0), 4 valid.
- Six letters pushed on consecutive cycles → `o_ready` falls after the 5th push (one letter is already popped), the 6th is dropped, `o_overflow`=1, exactly 5 cells are output.
- '3' (8'h33) → `o_dots`=0 with `o_dots_valid`=1 for 4 cycles, `o_bad_char`=1.
- Reset asserted in the 2nd hold cycle with 2 letters queued → all outputs 0 asynchronously, `o_ready`=1, and no cell is output after release.

Source files
------------

// File: rtl/braille_cell_driver.sv
// Queues ASCII letters from the classifier and presents each as a held 6-dot Braille cell.
// Optional blank gap between cells is compiled in with `define BRAILLE_CELL_GAP_EN.
module braille_cell_driver #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_alpha,
  output logic       o_ready,
  output logic [5:0] o_dots,
  output logic       o_dots_valid,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_bad_char
);

`ifdef BRAILLE_CELL_GAP_EN
  localparam int MAX_CYCLES = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
`else
  localparam int MAX_CYCLES = HOLD_CYCLES;
`endif
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
`ifdef BRAILLE_CELL_GAP_EN
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
`endif
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
    $error("HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  function automatic logic [5:0] a_to_j(input logic [3:0] n);
    case (n)
      4'd0:    return 6'b000001;
      4'd1:    return 6'b000011;
      4'd2:    return 6'b001001;
      4'd3:    return 6'b011001;
      4'd4:    return 6'b010001;
      4'd5:    return 6'b001011;
      4'd6:    return 6'b011011;
      4'd7:    return 6'b010011;
      4'd8:    return 6'b001010;
      default: return 6'b011010;
    endcase
  endfunction

  // Returns {bad, dots}; upper/lower case folded by clearing bit 5.
  function automatic logic [6:0] decode(input logic [7:0] c);
    logic [7:0] u;
    logic [4:0] idx;
    u = c & 8'hDF;
    if (u < 8'h41 || u > 8'h5A) return 7'b1_000000;
    idx = 5'(u - 8'h41);
    if (idx < 5'd10) return {1'b0, a_to_j(idx[3:0])};
    if (idx < 5'd20) return {1'b0, a_to_j(4'(idx - 5'd10)) | 6'b000100};
    case (idx)
      5'd20:   return 7'b0_100101;
      5'd21:   return 7'b0_100111;
      5'd22:   return 7'b0_111010;
      5'd23:   return 7'b0_101101;
      5'd24:   return 7'b0_111101;
      default: return 7'b0_110101;
    endcase
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [5:0]    dots_nx;
  logic          dots_valid_nx, bad_nx, pop, load;
  logic          push, nonempty, cnt_zero;
  logic [6:0]    head_dec;

  assign o_ready  = (count != FULL_COUNT);
  assign push     = i_valid && o_ready;
  assign nonempty = (count != '0);
  assign cnt_zero = (cnt == '0);
  assign head_dec = decode(mem[rd_ptr]);
  assign o_busy   = (state != IDLE) || nonempty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_alpha;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      o_dots       <= '0;
      o_dots_valid <= 1'b0;
      o_bad_char   <= 1'b0;
      o_overflow   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      o_dots       <= dots_nx;
      o_dots_valid <= dots_valid_nx;
      o_bad_char   <= bad_nx;
      o_overflow   <= o_overflow | (i_valid & ~o_ready);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (nonempty) state_nx = HOLD;
      HOLD: if (cnt_zero) begin
`ifdef BRAILLE_CELL_GAP_EN
        state_nx = GAP;
`else
        if (!nonempty) state_nx = IDLE;
`endif
      end
`ifdef BRAILLE_CELL_GAP_EN
      GAP:  if (cnt_zero) state_nx = nonempty ? HOLD : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // A "load" pops the head, decodes it and restarts the hold count in one edge.
  always_comb begin
    load          = 1'b0;
    cnt_nx        = cnt;
    dots_nx       = o_dots;
    dots_valid_nx = o_dots_valid;
    case (state)
      IDLE: load = nonempty;
      HOLD: begin
        if (!cnt_zero) begin
          cnt_nx = cnt - 1'b1;
        end else begin
`ifdef BRAILLE_CELL_GAP_EN
          dots_nx       = '0;
          dots_valid_nx = 1'b0;
          cnt_nx        = GAP_LOAD;
`else
          if (nonempty) begin
            load = 1'b1;
          end else begin
            dots_nx       = '0;
            dots_valid_nx = 1'b0;
          end
`endif
        end
      end
`ifdef BRAILLE_CELL_GAP_EN
      GAP: begin
        if (!cnt_zero) cnt_nx = cnt - 1'b1;
        else           load   = nonempty;
      end
`endif
      default: begin
        dots_nx       = '0;
        dots_valid_nx = 1'b0;
      end
    endcase
    pop    = load;
    bad_nx = o_bad_char | (load & head_dec[6]);
    if (load) begin
      dots_nx       = head_dec[5:0];
      dots_valid_nx = 1'b1;
      cnt_nx        = HOLD_LOAD;
    end
  end

endmodule

// File: tb/tb_braille_cell_driver.sv
// Self-checking bench for braille_cell_driver: decode table, multi-cell scoreboard,
// overflow and mid-cell reset. Follows the BRAILLE_CELL_GAP_EN setting of the build.
module tb_braille_cell_driver;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;
`ifdef BRAILLE_CELL_GAP_EN
  localparam int EXP_GAP = GAP;
`else
  localparam int EXP_GAP = 0;
`endif
  localparam int NV = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_alpha = 8'h00;
  logic       o_ready, o_dots_valid, o_busy, o_overflow, o_bad_char;
  logic [5:0] o_dots;

  braille_cell_driver #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_alpha(i_alpha),
    .o_ready(o_ready), .o_dots(o_dots), .o_dots_valid(o_dots_valid),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_bad_char(o_bad_char)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] alpha;
    logic [5:0] dots;
    logic       bad;
  } vec_t;
  vec_t vecs [NV];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [5:0] exp_q [$];
  logic [5:0] cur = '0;
  bit mon_en = 1'b0;
  bit seen = 1'b0;
  int run_len = 0, blank = 0, cells = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Scoreboard monitor: each cell is HOLD cycles, separated by EXP_GAP blank cycles.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (o_dots_valid) begin
        if (run_len == 0) begin
          if (seen) chk("gap_len", blank, EXP_GAP);
          chk("cell_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          cells++;
          seen = 1'b1;
          blank = 0;
        end
        chk("cell_dots", o_dots, cur);
        run_len++;
        if (run_len == HOLD) run_len = 0;
      end else begin
        if (run_len != 0) begin
          chk("short_cell", run_len, HOLD);
          run_len = 0;
        end
        blank++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("rst_dots", o_dots, 0);
    chk("rst_valid", o_dots_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_flags", {o_overflow, o_bad_char}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [5:0] d, input bit exp_rdy);
    chk("ready_before_push", o_ready, exp_rdy);
    i_valid = 1'b1;
    i_alpha = a;
    if (exp_rdy) exp_q.push_back(d);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic start_seq();
    do_reset();
    exp_q.delete();
    run_len = 0;
    blank = 0;
    cells = 0;
    seen = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic end_seq(input string name, input int ncells);
    for (int k = 0; k < 200 && o_busy; k++) @(negedge clk);
    chk({name, "_idle_timeout"}, o_busy, 0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk({name, "_cells"}, cells, ncells);
    chk({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h61, 6'b000001, 1'b0};  // a
    vecs[1]  = '{8'h41, 6'b000001, 1'b0};  // A
    vecs[2]  = '{8'h7A, 6'b110101, 1'b0};  // z
    vecs[3]  = '{8'h6B, 6'b000101, 1'b0};  // k
    vecs[4]  = '{8'h54, 6'b011110, 1'b0};  // T
    vecs[5]  = '{8'h4D, 6'b001101, 1'b0};  // M
    vecs[6]  = '{8'h77, 6'b111010, 1'b0};  // w
    vecs[7]  = '{8'h79, 6'b111101, 1'b0};  // y
    vecs[8]  = '{8'h75, 6'b100101, 1'b0};  // u
    vecs[9]  = '{8'h78, 6'b101101, 1'b0};  // x
    vecs[10] = '{8'h33, 6'b000000, 1'b1};  // 3
    vecs[11] = '{8'h40, 6'b000000, 1'b1};  // @
    vecs[12] = '{8'h5B, 6'b000000, 1'b1};  // [
    vecs[13] = '{8'h7B, 6'b000000, 1'b1};  // {

    // Single-letter table: latency, hold length, return to idle, bad-char flag.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      i_valid = 1'b1;
      i_alpha = vecs[i].alpha;
      @(negedge clk);
      i_valid = 1'b0;
      chk($sformatf("v%0d_not_yet", i), o_dots_valid, 0);
      @(negedge clk);
      for (int k = 0; k < HOLD; k++) begin
        chk($sformatf("v%0d_dots_c%0d", i, k), o_dots, vecs[i].dots);
        chk($sformatf("v%0d_valid_c%0d", i, k), o_dots_valid, 1);
        @(negedge clk);
      end
      chk($sformatf("v%0d_end_valid", i), o_dots_valid, 0);
      chk($sformatf("v%0d_end_dots", i), o_dots, 0);
      chk($sformatf("v%0d_end_busy", i), o_busy, 0);
      chk($sformatf("v%0d_bad_char", i), o_bad_char, vecs[i].bad);
    end

    // 'A' then 'z' back to back.
    start_seq();
    push(8'h41, 6'b000001, 1'b1);
    push(8'h7A, 6'b110101, 1'b1);
    end_seq("az", 2);

    // Six consecutive letters: fifth fills the queue, sixth is dropped.
    start_seq();
    push(8'h62, 6'b000011, 1'b1);
    push(8'h63, 6'b001001, 1'b1);
    push(8'h64, 6'b011001, 1'b1);
    push(8'h65, 6'b010001, 1'b1);
    push(8'h66, 6'b001011, 1'b1);
    push(8'h67, 6'b011011, 1'b0);
    chk("six_overflow", o_overflow, 1);
    end_seq("six", 5);
    chk("six_overflow_sticky", o_overflow, 1);
    chk("six_no_bad", o_bad_char, 0);

    // Reset in the second hold cycle with two letters still queued.
    do_reset();
    push(8'h68, 6'b010011, 1'b1);
    push(8'h69, 6'b001010, 1'b1);
    push(8'h6A, 6'b011010, 1'b1);
    exp_q.delete();
    chk("mid_valid", o_dots_valid, 1);
    chk("mid_dots", o_dots, 6'b010011);
    reset = 1'b1;
    #1;
    chk("async_dots", o_dots, 0);
    chk("async_valid", o_dots_valid, 0);
    chk("async_ready", o_ready, 1);
    chk("async_busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen_v;
      seen_v = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (o_dots_valid || o_busy) seen_v++;
      end
      chk("post_reset_no_cell", seen_v, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
